// File: rtl/squash_unit_l1_pkg.sv
// Shared types and the age comparison used by the squash arbiter and its users.
package squash_unit_l1_pkg;

  // Widest sequence number any configuration uses; narrower ones zero-extend.
  localparam int SEQ_MAX_W = 8;

  typedef logic [SEQ_MAX_W-1:0] seq_num_t;

  typedef struct packed {
    seq_num_t    seq_num;
    logic [31:0] target;
  } squash_msg_t;

  typedef struct packed {
    logic [31:0] pc;
    seq_num_t    seq_num;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } commit_msg_t;

  // Distance of s from the commit head, modulo 2^w.
  function automatic seq_num_t seq_age(input seq_num_t s, input seq_num_t head,
                                       input int unsigned w);
    seq_num_t mask;
    mask = SEQ_MAX_W'((1 << w) - 1);
    return (s - head) & mask;
  endfunction

  // True when a is strictly closer to the head than b.
  function automatic logic is_older(input seq_num_t a, input seq_num_t b,
                                    input seq_num_t head, input int unsigned w);
    return seq_age(a, head, w) < seq_age(b, head, w);
  endfunction

endpackage

// File: rtl/squash_unit_l1_seq_age.sv
// Commit-stream age reference: head points one past the last committed instruction.
module squash_unit_l1_seq_age #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_val,
  input  logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [p_seq_num_bits-1:0] head
);

  // Advance head on each commit; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            head <= '0;
    else if (commit_val) head <= p_seq_num_bits'(commit_seq_num + 1'b1);
  end

endmodule

// File: rtl/squash_unit_l1.sv
// Level-1 squash arbiter: forwards the oldest same-cycle squash request.
module squash_unit_l1
  import squash_unit_l1_pkg::*;
#(
  parameter int p_num_arb      = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [p_num_arb-1:0]                     arb_val,
  input  logic [p_num_arb-1:0][p_seq_num_bits-1:0] arb_seq_num,
  input  logic [p_num_arb-1:0][31:0]               arb_target,
  output logic                                     gnt_val,
  output logic [p_seq_num_bits-1:0]                gnt_seq_num,
  output logic [31:0]                              gnt_target,
  input  logic                                     commit_val,
  input  logic [p_seq_num_bits-1:0]                commit_seq_num,
  input  logic [31:0]                              commit_pc,
  input  logic [4:0]                               commit_waddr,
  input  logic [31:0]                              commit_wdata,
  input  logic                                     commit_wen
);

  logic [p_seq_num_bits-1:0] head;
  commit_msg_t               commit_msg;
  squash_msg_t               best;
  logic                      found;
  logic                      unused_commit;

  squash_unit_l1_seq_age #(.p_seq_num_bits(p_seq_num_bits)) u_seq_age (
    .clk            (clk),
    .rst            (rst),
    .commit_val     (commit_val),
    .commit_seq_num (commit_seq_num),
    .head           (head)
  );

  // Only the sequence number of the commit bundle matters for ageing.
  assign commit_msg = '{pc: commit_pc, seq_num: SEQ_MAX_W'(commit_seq_num),
                        waddr: commit_waddr, wdata: commit_wdata, wen: commit_wen};
  assign unused_commit = ^{commit_msg.pc, commit_msg.waddr, commit_msg.wdata, commit_msg.wen};

  // Linear reduction; strict is_older keeps the lower index on age ties.
  always_comb begin
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < p_num_arb; i++) begin
      if (arb_val[i] && (!found ||
          is_older(SEQ_MAX_W'(arb_seq_num[i]), best.seq_num, SEQ_MAX_W'(head),
                   p_seq_num_bits))) begin
        best.seq_num = SEQ_MAX_W'(arb_seq_num[i]);
        best.target  = arb_target[i];
        found        = 1'b1;
      end
    end
  end

  // best stays zero when nothing is valid, so outputs are zero with gnt_val low.
  assign gnt_val     = found;
  assign gnt_seq_num = best.seq_num[p_seq_num_bits-1:0];
  assign gnt_target  = best.target;

endmodule

// File: tb/tb_squash_unit_l1.sv
// Bench for squash_unit_l1: directed table, hand-written reset sequence, random regression.
module tb_squash_unit_l1;

  localparam int NA = 20;
  localparam int SW = 5;
  localparam int MOD = 1 << SW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NA-1:0]          arb_val;
  logic [NA-1:0][SW-1:0]  arb_seq_num;
  logic [NA-1:0][31:0]    arb_target;
  logic                   gnt_val;
  logic [SW-1:0]          gnt_seq_num;
  logic [31:0]            gnt_target;
  logic                   commit_val;
  logic [SW-1:0]          commit_seq_num;
  logic [31:0]            commit_pc;
  logic [4:0]             commit_waddr;
  logic [31:0]            commit_wdata;
  logic                   commit_wen;

  squash_unit_l1 #(.p_num_arb(NA), .p_seq_num_bits(SW)) dut (
    .clk(clk), .rst(rst),
    .arb_val(arb_val), .arb_seq_num(arb_seq_num), .arb_target(arb_target),
    .gnt_val(gnt_val), .gnt_seq_num(gnt_seq_num), .gnt_target(gnt_target),
    .commit_val(commit_val), .commit_seq_num(commit_seq_num),
    .commit_pc(commit_pc), .commit_waddr(commit_waddr),
    .commit_wdata(commit_wdata), .commit_wen(commit_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [SW-1:0] s;
    logic [31:0]   t;
  } exp_t;

  typedef struct {
    string         nm;
    logic          cv;
    logic [SW-1:0] cs;
    int            ia;
    logic [SW-1:0] qa;
    logic [31:0]   ta;
    int            ib;
    logic [SW-1:0] qb;
    logic [31:0]   tb;
    exp_t          e;
  } vec_t;

  exp_t                  sb[$];
  vec_t                  vecs[7];
  logic [NA-1:0]         st_val;
  logic [NA-1:0][SW-1:0] st_seq;
  logic [NA-1:0][31:0]   st_tgt;
  int                    tb_head;
  int                    n_chk = 0;
  int                    n_pass = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int age(input int s, input int h);
    return (s - h + MOD) % MOD;
  endfunction

  // Reference arbiter written independently of the RTL: smallest age, first index wins ties.
  function automatic exp_t model();
    exp_t e;
    int   best_age;
    e = '{v: 1'b0, s: '0, t: '0};
    best_age = MOD;
    for (int i = 0; i < NA; i++)
      if (st_val[i] && age(int'(st_seq[i]), tb_head) < best_age) begin
        best_age = age(int'(st_seq[i]), tb_head);
        e = '{v: 1'b1, s: st_seq[i], t: st_tgt[i]};
      end
    return e;
  endfunction

  task automatic clear_stage();
    st_val = '0;
    st_seq = '0;
    st_tgt = '0;
  endtask

  // One cycle: drive staged request + commit, queue expectation, compare at negedge.
  task automatic run_cycle(input string nm, input logic cv, input logic [SW-1:0] cs,
                           input exp_t e);
    exp_t got;
    @(posedge clk); #1;
    commit_val     = cv;
    commit_seq_num = cs;
    arb_val        = st_val;
    arb_seq_num    = st_seq;
    arb_target     = st_tgt;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    cmp({nm, ".val"}, {31'd0, gnt_val}, {31'd0, got.v});
    cmp({nm, ".seq"}, {27'd0, gnt_seq_num}, {27'd0, got.s});
    cmp({nm, ".tgt"}, gnt_target, got.t);
    if (cv) tb_head = (int'(cs) + 1) % MOD;
  endtask

  initial begin
    exp_t idle;
    int   perm[MOD];
    idle = '{v: 1'b0, s: '0, t: '0};

    vecs[0] = '{"two_src", 0, 0, 0, 5, 32'hA0, 1, 3, 32'hB0, '{1, 3, 32'hB0}};
    vecs[1] = '{"commit28", 1, 28, -1, 0, 0, -1, 0, 0, '{0, 0, 0}};
    vecs[2] = '{"wrap", 0, 0, 0, 30, 32'h10, 1, 2, 32'h20, '{1, 30, 32'h10}};
    vecs[3] = '{"commit31", 1, 31, -1, 0, 0, -1, 0, 0, '{0, 0, 0}};
    vecs[4] = '{"same_cyc_commit", 1, 10, 0, 1, 32'h1, 1, 12, 32'hC, '{1, 1, 32'h1}};
    vecs[5] = '{"after_commit", 0, 0, 0, 1, 32'h1, 1, 12, 32'hC, '{1, 12, 32'hC}};
    vecs[6] = '{"tie_2_5", 0, 0, 5, 7, 32'h75, 2, 7, 32'h72, '{1, 7, 32'h72}};

    rst = 1'b0; commit_val = 1'b0; commit_seq_num = '0;
    commit_pc = 32'h1234; commit_waddr = 5'd3; commit_wdata = 32'hDEAD; commit_wen = 1'b1;
    arb_val = '0; arb_seq_num = '0; arb_target = '0;
    tb_head = 0;
    clear_stage();

    // Reset state, then combinational grant while still in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst.val", {31'd0, gnt_val}, 32'd0);
    cmp("rst.tgt", gnt_target, 32'd0);
    arb_val[3] = 1'b1; arb_seq_num[3] = 5'd9; arb_target[3] = 32'h333;
    #1;
    cmp("rst_pass.val", {31'd0, gnt_val}, 32'd1);
    cmp("rst_pass.tgt", gnt_target, 32'h333);
    arb_val = '0;
    @(posedge clk); #1 rst = 1'b1;

    // Each source alone, then idle the next cycle.
    for (int i = 0; i < NA; i++) begin
      clear_stage();
      st_val[i] = 1'b1; st_seq[i] = 5'h0B; st_tgt[i] = 32'h8000_0000 + i;
      run_cycle($sformatf("solo%0d", i), 0, 0, '{1, 5'h0B, 32'h8000_0000 + i});
      clear_stage();
      run_cycle($sformatf("solo%0d_idle", i), 0, 0, idle);
    end

    // Directed table.
    for (int k = 0; k < 7; k++) begin
      clear_stage();
      if (vecs[k].ia >= 0) begin
        st_val[vecs[k].ia] = 1'b1; st_seq[vecs[k].ia] = vecs[k].qa; st_tgt[vecs[k].ia] = vecs[k].ta;
      end
      if (vecs[k].ib >= 0) begin
        st_val[vecs[k].ib] = 1'b1; st_seq[vecs[k].ib] = vecs[k].qb; st_tgt[vecs[k].ib] = vecs[k].tb;
      end
      run_cycle(vecs[k].nm, vecs[k].cv, vecs[k].cs, vecs[k].e);
    end

    // head is 11: seq 11 (age 0) from src19 beats seq 10 (age 31) from src3.
    clear_stage();
    st_val[3] = 1'b1; st_seq[3] = 5'd10; st_tgt[3] = 32'h300;
    st_val[19] = 1'b1; st_seq[19] = 5'd11; st_tgt[19] = 32'h1900;
    run_cycle("age0_high_idx", 0, 0, '{1, 11, 32'h1900});

    // Mid-stream async reset: head drops to 0 at once, so seq 10 now wins.
    @(posedge clk); #1;
    commit_val = 1'b0;
    arb_val = '0; arb_seq_num = '0; arb_target = '0;
    arb_val[0] = 1'b1; arb_seq_num[0] = 5'd10; arb_target[0] = 32'hAA;
    arb_val[1] = 1'b1; arb_seq_num[1] = 5'd11; arb_target[1] = 32'hBB;
    #1;
    cmp("pre_rst.seq", {27'd0, gnt_seq_num}, 32'd11);
    #1 rst = 1'b0;
    #1;
    cmp("mid_rst.val", {31'd0, gnt_val}, 32'd1);
    cmp("mid_rst.seq", {27'd0, gnt_seq_num}, 32'd10);
    cmp("mid_rst.tgt", gnt_target, 32'hAA);
    @(posedge clk); #1 rst = 1'b1;
    tb_head = 0;

    // Random regression: commit cycle, then a distinct-seq random subset (sometimes with commit).
    for (int it = 0; it < 30; it++) begin
      logic [SW-1:0] cs;
      logic          cv2;
      clear_stage();
      cs = SW'($urandom_range(MOD - 1));
      run_cycle($sformatf("rnd%0d_commit", it), 1, cs, idle);
      for (int j = 0; j < MOD; j++) perm[j] = j;
      for (int j = MOD - 1; j > 0; j--) begin
        int r, tmp;
        r = $urandom_range(j);
        tmp = perm[j]; perm[j] = perm[r]; perm[r] = tmp;
      end
      st_val = NA'($urandom());
      for (int i = 0; i < NA; i++) begin
        st_seq[i] = SW'(perm[i]);
        st_tgt[i] = $urandom();
      end
      cv2 = 1'($urandom_range(1));
      run_cycle($sformatf("rnd%0d_arb", it), cv2, SW'($urandom_range(MOD - 1)), model());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
